// File: rtl/mem_stage_ws.sv
// Pipeline memory stage with word-organised data RAM, RV32 B/H/W loads and stores,
// optional wait states that stall upstream, misalignment detection and flush.
module mem_stage_ws #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FlushM,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW
);

  localparam int AW = $clog2(DEPTH);
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        complete;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    off;
  logic          is_half, is_word, mem_op, misaligned, access;
  logic [31:0]   rdata, load_ext, st_data;
  logic [3:0]    st_be;
  logic          we;

  assign word_idx   = ALU_ResultM[AW+1:2];
  assign off        = ALU_ResultM[1:0];
  assign is_half    = (Funct3M == 3'b001) || (Funct3M == 3'b101);
  assign is_word    = (Funct3M == 3'b010);
  assign mem_op     = MemReadM | MemWriteM;
  assign misaligned = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign access     = mem_op & ~misaligned & ~FlushM;

  // Flush wins over everything; a completing cycle is the only one that touches RAM or W.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    StallM   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (FlushM) begin
          state_d = IDLE;
        end else if (access && HAS_WAIT) begin
          StallM  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else begin
          complete = 1'b1;
        end
      end
      BUSY: begin
        if (FlushM) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          StallM = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (Funct3M)
      3'b000: begin
        st_be   = 4'b0001 << off;
        st_data = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{WriteDataM[15:0]}};
      end
      3'b010: begin
        st_be   = 4'b1111;
        st_data = WriteDataM;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  assign rdata = mem[word_idx];

  always_comb begin
    load_ext = rdata;
    case (Funct3M)
      3'b000:  load_ext = {{24{rdata[{off, 3'b000} + 7]}}, rdata[{off, 3'b000} +: 8]};
      3'b100:  load_ext = {24'h0, rdata[{off, 3'b000} +: 8]};
      3'b001:  load_ext = {{16{rdata[{off[1], 4'b0000} + 15]}}, rdata[{off[1], 4'b0000} +: 16]};
      3'b101:  load_ext = {16'h0, rdata[{off[1], 4'b0000} +: 16]};
      default: load_ext = rdata;
    endcase
  end

  // A reset in the same cycle discards any pending store.
  assign we = complete & MemWriteM & ~misaligned & ~rst;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && st_be[i]) begin
        mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= 5'd0;
      PCPlus4W    <= 32'h0;
      ALU_ResultW <= 32'h0;
      ReadDataW   <= 32'h0;
      MisalignW   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete) begin
        RegWriteW   <= RegWriteM & ~misaligned;
        ResultSrcW  <= ResultSrcM;
        RD_W        <= RD_M;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
        ReadDataW   <= MemReadM ? load_ext : 32'h0;
        MisalignW   <= misaligned;
      end else begin
        RegWriteW   <= 1'b0;
        ResultSrcW  <= 1'b0;
        RD_W        <= 5'd0;
        PCPlus4W    <= 32'h0;
        ALU_ResultW <= 32'h0;
        ReadDataW   <= 32'h0;
        MisalignW   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: a zero-wait and a three-wait instance share one stimulus stream;
// expected W-register contents are queued at drive time and compared when the DUT completes.
module tb_mem_stage_ws;

  logic        clk = 1'b0;
  logic        rst, FlushM, RegWriteM, MemReadM, MemWriteM, ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  logic        stall0, rw0, rs0, mis0;
  logic [4:0]  rd0;
  logic [31:0] pc0, alu0, rdat0;
  logic        stall3, rw3, rs3, mis3;
  logic [4:0]  rd3;
  logic [31:0] pc3, alu3, rdat3;

  int total = 0;
  int bad   = 0;
  logic [31:0] pc = 32'h1000;

  typedef struct {
    string       tag;
    logic        rw, rs, mis;
    logic [4:0]  rd;
    logic [31:0] pc, alu, rdata;
    bit          chk_rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage_ws #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .FlushM(FlushM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .StallM(stall0), .RegWriteW(rw0), .ResultSrcW(rs0), .RD_W(rd0), .PCPlus4W(pc0),
    .ALU_ResultW(alu0), .ReadDataW(rdat0), .MisalignW(mis0));

  mem_stage_ws #(.DEPTH(64), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .FlushM(FlushM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .StallM(stall3), .RegWriteW(rw3), .ResultSrcW(rs3), .RD_W(rd3), .PCPlus4W(pc3),
    .ALU_ResultW(alu3), .ReadDataW(rdat3), .MisalignW(mis3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fl, rw, mr, mw, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] p, wd, alu);
    FlushM = fl; RegWriteM = rw; MemReadM = mr; MemWriteM = mw; ResultSrcM = mr;
    Funct3M = f3; RD_M = rd; PCPlus4M = p; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  task automatic applyStimulus(input string tag, input logic fl, rw, mr, mw, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [31:0] p, wd, alu, erd,
                               input logic emis, input bit chkrd);
    exp_t e;
    drive(fl, rw, mr, mw, f3, rd, p, wd, alu);
    e.tag = tag;
    if (fl) begin
      e.rw = 0; e.rs = 0; e.mis = 0; e.rd = 0; e.pc = 0; e.alu = 0; e.rdata = 0; e.chk_rdata = 1;
    end else begin
      e.rw = rw & ~emis; e.rs = mr; e.mis = emis; e.rd = rd; e.pc = p; e.alu = alu;
      e.rdata = erd; e.chk_rdata = chkrd;
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input bit sel);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "/RegWriteW"},   32'(sel ? rw3 : rw0),   32'(e.rw));
    chk({e.tag, "/ResultSrcW"},  32'(sel ? rs3 : rs0),   32'(e.rs));
    chk({e.tag, "/RD_W"},        32'(sel ? rd3 : rd0),   32'(e.rd));
    chk({e.tag, "/PCPlus4W"},    sel ? pc3 : pc0,        e.pc);
    chk({e.tag, "/ALU_ResultW"}, sel ? alu3 : alu0,      e.alu);
    chk({e.tag, "/MisalignW"},   32'(sel ? mis3 : mis0), 32'(e.mis));
    if (e.chk_rdata) chk({e.tag, "/ReadDataW"}, sel ? rdat3 : rdat0, e.rdata);
  endtask

  task automatic op0(input string tag, input logic fl, rw, mr, mw, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [31:0] wd, alu, erd,
                     input logic emis, input bit chkrd);
    pc += 4;
    applyStimulus(tag, fl, rw, mr, mw, f3, rd, pc, wd, alu, erd, emis, chkrd);
    #1 chk({tag, "/StallM"}, 32'(stall0), 32'd0);
    @(posedge clk); #1;
    checkOutput(0);
  endtask

  task automatic op3(input string tag, input logic rw, mr, mw, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [31:0] wd, alu, erd,
                     input logic emis, input bit chkrd, input int nexp);
    int n = 0;
    bit done = 0;
    pc += 4;
    applyStimulus(tag, 1'b0, rw, mr, mw, f3, rd, pc, wd, alu, erd, emis, chkrd);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (stall3) begin
        n++;
        @(posedge clk); #1;
        chk({tag, "/stall_bubble_rw"}, 32'(rw3), 32'd0);
        chk({tag, "/stall_bubble_pc"}, pc3, 32'd0);
      end else begin
        done = 1;
      end
    end
    if (!done) chk({tag, "/stall_timeout"}, 32'd1, 32'd0);
    chk({tag, "/stall_cycles"}, 32'(n), 32'(nexp));
    @(posedge clk); #1;
    checkOutput(1);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset/rw0", 32'(rw0), 32'd0);
    chk("reset/pc0", pc0, 32'd0);
    chk("reset/rdat3", rdat3, 32'd0);
    chk("reset/alu3", alu3, 32'd0);
    rst = 0;
    #1;
    chk("reset/stall0", 32'(stall0), 32'd0);
    chk("reset/stall3", 32'(stall3), 32'd0);

    op0("sw10",   0, 0, 0, 1, 3'b010, 5'd0, 32'hDEADBEEF, 32'h10, 32'h0,        0, 1);
    op0("lw10",   0, 1, 1, 0, 3'b010, 5'd5, 32'h0,        32'h10, 32'hDEADBEEF, 0, 1);
    op0("sb13",   0, 0, 0, 1, 3'b000, 5'd0, 32'h12345680, 32'h13, 32'h0,        0, 1);
    op0("lb13",   0, 1, 1, 0, 3'b000, 5'd6, 32'h0,        32'h13, 32'hFFFFFF80, 0, 1);
    op0("lbu13",  0, 1, 1, 0, 3'b100, 5'd6, 32'h0,        32'h13, 32'h00000080, 0, 1);
    op0("lw10b",  0, 1, 1, 0, 3'b010, 5'd5, 32'h0,        32'h10, 32'h80ADBEEF, 0, 1);
    op0("lb12",   0, 1, 1, 0, 3'b000, 5'd6, 32'h0,        32'h12, 32'hFFFFFFAD, 0, 1);
    op0("lbu11",  0, 1, 1, 0, 3'b100, 5'd6, 32'h0,        32'h11, 32'h000000BE, 0, 1);
    op0("sw20",   0, 0, 0, 1, 3'b010, 5'd0, 32'h11223344, 32'h20, 32'h0,        0, 1);
    op0("sh22",   0, 0, 0, 1, 3'b001, 5'd0, 32'hFFFF8001, 32'h22, 32'h0,        0, 1);
    op0("lh22",   0, 1, 1, 0, 3'b001, 5'd7, 32'h0,        32'h22, 32'hFFFF8001, 0, 1);
    op0("lhu22",  0, 1, 1, 0, 3'b101, 5'd7, 32'h0,        32'h22, 32'h00008001, 0, 1);
    op0("lh20",   0, 1, 1, 0, 3'b001, 5'd7, 32'h0,        32'h20, 32'h00003344, 0, 1);
    op0("lw20",   0, 1, 1, 0, 3'b010, 5'd7, 32'h0,        32'h20, 32'h80013344, 0, 1);
    op0("mis_lw11", 0, 1, 1, 0, 3'b010, 5'd7, 32'h0,      32'h11, 32'h0,        1, 0);
    op0("mis_sh21", 0, 0, 0, 1, 3'b001, 5'd0, 32'h0000AAAA, 32'h21, 32'h0,      1, 1);
    op0("lw20c",  0, 1, 1, 0, 3'b010, 5'd7, 32'h0,        32'h20, 32'h80013344, 0, 1);
    op0("alias110", 0, 1, 1, 0, 3'b010, 5'd8, 32'h0,      32'h110, 32'h80ADBEEF, 0, 1);
    op0("alu_op", 0, 1, 0, 0, 3'b000, 5'd3, 32'h0,        32'h55, 32'h0,        0, 1);
    op0("flush_sw", 1, 0, 0, 1, 3'b010, 5'd0, 32'h0,      32'h10, 32'h0,        0, 1);
    op0("lw10c",  0, 1, 1, 0, 3'b010, 5'd5, 32'h0,        32'h10, 32'h80ADBEEF, 0, 1);
    op0("undef110", 0, 1, 1, 0, 3'b110, 5'd4, 32'h0,      32'h10, 32'h80ADBEEF, 0, 1);

    $display("[TB] wait-state section");
    rst = 1;
    drive(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    op3("w_sw40", 0, 0, 1, 3'b010, 5'd0, 32'hCAFEF00D, 32'h40, 32'h0,        0, 1, 3);
    op3("w_lw40", 1, 1, 0, 3'b010, 5'd9, 32'h0,        32'h40, 32'hCAFEF00D, 0, 1, 3);

    pc += 4;
    drive(0, 0, 0, 1, 3'b010, 5'd0, pc, 32'h12345678, 32'h40);
    #1 chk("flush/first_stall", 32'(stall3), 32'd1);
    @(posedge clk); #1;
    chk("flush/bubble_rw", 32'(rw3), 32'd0);
    applyStimulus("flush", 1, 0, 0, 1, 3'b010, 5'd0, pc, 32'h12345678, 32'h40, 32'h0, 0, 1);
    #1 chk("flush/stall_released", 32'(stall3), 32'd0);
    @(posedge clk); #1;
    checkOutput(1);
    op3("w_lw40_after_flush", 1, 1, 0, 3'b010, 5'd9, 32'h0, 32'h40, 32'hCAFEF00D, 0, 1, 3);

    op3("w_sw44", 0, 0, 1, 3'b010, 5'd0, 32'h11111111, 32'h44, 32'h0, 0, 1, 3);
    pc += 4;
    drive(0, 0, 0, 1, 3'b010, 5'd0, pc, 32'h22222222, 32'h44);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid/rw", 32'(rw3), 32'd0);
    chk("rst_mid/pc", pc3, 32'd0);
    drive(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    #1 chk("rst_mid/stall", 32'(stall3), 32'd0);
    op3("w_lw44_after_rst", 1, 1, 0, 3'b010, 5'd10, 32'h0, 32'h44, 32'h11111111, 0, 1, 3);

    op3("w_mis41", 1, 1, 0, 3'b010, 5'd2, 32'h0, 32'h41, 32'h0, 1, 0, 0);
    op3("w_alu",   1, 0, 0, 3'b000, 5'd3, 32'h0, 32'h77, 32'h0, 0, 1, 0);

    if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
